// File: rtl/move_sequencer.sv
// Move sequencer: queues stepper move codes and issues them one at a time
// with a start/done handshake. Define MOVE_SETTLE_EN to add a settle gap between moves.
module move_sequencer #(
  parameter int unsigned DEPTH         = 16,
  parameter int unsigned START_TIMEOUT = 1024,
  parameter int unsigned SETTLE_CYCLES = 2500000
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [3:0]               move_in,
  input  logic                     move_valid,
  output logic                     move_ready,
  input  logic                     flush,
  input  logic                     pause,
  output logic [3:0]               next_move,
  output logic                     move_start,
  input  logic                     move_done,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   level,
  output logic [15:0]              moves_completed,
  output logic                     error
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned TW = $clog2(START_TIMEOUT + 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_ISSUE     = 3'd1;
  localparam logic [2:0] S_WAIT_BUSY = 3'd2;
  localparam logic [2:0] S_WAIT_DONE = 3'd3;
`ifdef MOVE_SETTLE_EN
  localparam logic [2:0] S_SETTLE    = 3'd4;
  localparam int unsigned SW = $clog2(SETTLE_CYCLES + 1);
`endif

  logic [2:0]    state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [3:0]    next_move_q, next_move_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [15:0]   done_cnt_q, done_cnt_d;
  logic          error_q, error_d;
  logic          ready_q;
`ifdef MOVE_SETTLE_EN
  logic [SW-1:0] settle_q, settle_d;
`endif

  logic [3:0] mem [DEPTH];

  logic full;
  logic accept;
  logic code_ok;
  logic push;
  logic pop;

  assign full       = (level_q == LW'(DEPTH));
  assign move_ready = ready_q & ~full;
  assign accept     = move_valid & move_ready;
  assign code_ok    = (move_in >= 4'd2) && (move_in <= 4'd13);
  assign push       = accept & code_ok & ~flush;
  // Dequeue happens on the IDLE->ISSUE edge so next_move is already valid
  // while move_start is high.
  assign pop        = (state_q == S_IDLE) && (level_q != '0) && !pause && move_done;

  assign next_move       = next_move_q;
  assign move_start      = (state_q == S_ISSUE);
  assign busy            = (state_q != S_IDLE);
  assign level           = level_q;
  assign moves_completed = done_cnt_q;
  assign error           = error_q;

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    next_move_d = next_move_q;
    tmo_d       = tmo_q;
    done_cnt_d  = done_cnt_q;
    error_d     = error_q;
`ifdef MOVE_SETTLE_EN
    settle_d    = settle_q;
`endif

    if (accept && !code_ok) error_d = 1'b1;

    if (flush) begin
      rd_ptr_d = wr_ptr_q;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      level_d = level_q + LW'(push) - LW'(pop);
    end

    case (state_q)
      S_IDLE: begin
        if (pop) begin
          state_d     = S_ISSUE;
          next_move_d = mem[rd_ptr_q];
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT_BUSY;
        tmo_d   = '0;
      end
      S_WAIT_BUSY: begin
        if (!move_done) begin
          state_d = S_WAIT_DONE;
        end else if (tmo_q == TW'(START_TIMEOUT - 1)) begin
          state_d = S_IDLE;
          error_d = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_WAIT_DONE: begin
        if (move_done) begin
          done_cnt_d = done_cnt_q + 16'd1;
`ifdef MOVE_SETTLE_EN
          state_d  = S_SETTLE;
          settle_d = '0;
`else
          state_d  = S_IDLE;
`endif
        end
      end
`ifdef MOVE_SETTLE_EN
      S_SETTLE: begin
        if (settle_q == SW'(SETTLE_CYCLES - 1)) state_d = S_IDLE;
        else                                    settle_d = settle_q + 1'b1;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      next_move_q <= '0;
      tmo_q       <= '0;
      done_cnt_q  <= '0;
      error_q     <= 1'b0;
      ready_q     <= 1'b0;
`ifdef MOVE_SETTLE_EN
      settle_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      next_move_q <= next_move_d;
      tmo_q       <= tmo_d;
      done_cnt_q  <= done_cnt_d;
      error_q     <= error_d;
      ready_q     <= 1'b1;
`ifdef MOVE_SETTLE_EN
      settle_q    <= settle_d;
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr_q] <= move_in;
  end

endmodule

// File: tb/tb_move_sequencer.sv
// Directed bench for move_sequencer (default build, MOVE_SETTLE_EN undefined),
// with a simple stepper model that drops move_done for 20 cycles per move.
module tb_move_sequencer;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  move_in = '0;
  logic        move_valid = 1'b0;
  logic        move_ready;
  logic        flush = 1'b0;
  logic        pause = 1'b0;
  logic [3:0]  next_move;
  logic        move_start;
  logic        move_done = 1'b1;
  logic        busy;
  logic [4:0]  level;
  logic [15:0] moves_completed;
  logic        error;

  int unsigned errors = 0;
  int unsigned checks = 0;
  logic        dp_auto = 1'b1;
  logic [3:0]  starts[$];
  logic [3:0]  last_nm = '0;
  int unsigned unstable = 0;

  move_sequencer #(.DEPTH(16), .START_TIMEOUT(1024)) dut (
    .clock(clock), .reset_n(reset_n), .move_in(move_in), .move_valid(move_valid),
    .move_ready(move_ready), .flush(flush), .pause(pause), .next_move(next_move),
    .move_start(move_start), .move_done(move_done), .busy(busy), .level(level),
    .moves_completed(moves_completed), .error(error)
  );

  always #5 clock = ~clock;

  // Stepper model: busy low 2 cycles after move_start, for 20 cycles.
  initial begin
    forever begin
      @(negedge clock);
      if (dp_auto && move_start) begin
        repeat (2) @(negedge clock);
        move_done = 1'b0;
        repeat (20) @(negedge clock);
        move_done = 1'b1;
      end
    end
  end

  // Log every issued move and watch next_move stability while busy.
  initial begin
    forever begin
      @(negedge clock);
      if (move_start) begin
        starts.push_back(next_move);
        last_nm = next_move;
      end else if (busy && next_move != last_nm) begin
        unstable++;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic enq(input logic [3:0] code);
    @(negedge clock);
    move_in    = code;
    move_valid = 1'b1;
    @(negedge clock);
    move_valid = 1'b0;
  endtask

  task automatic pulse_flush();
    @(negedge clock);
    flush = 1'b1;
    @(negedge clock);
    flush = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int unsigned budget);
    int unsigned n = 0;
    while ((busy || level != 0) && n < budget) begin
      @(negedge clock);
      n++;
    end
    check(tag, 32'(n < budget), 32'd1);
  endtask

  task automatic wait_wait_done(input string tag);
    int unsigned n = 0;
    while (move_done && n < 100) begin
      @(negedge clock);
      n++;
    end
    check(tag, 32'(move_done), 32'd0);
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    check("rst_level", 32'(level), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready_held", 32'(move_ready), 32'd0);
    reset_n = 1'b1;
    #1;
    check("rst_ready_rel", 32'(move_ready), 32'd0);
    @(negedge clock);
    check("rst_ready_after", 32'(move_ready), 32'd1);
  endtask

  function automatic logic [3:0] start_at(input int unsigned idx);
    return (idx < starts.size()) ? starts[idx] : 4'hF;
  endfunction

  initial begin
    int unsigned n0;

    // Reset values
    do_reset();
    check("rst_next_move", 32'(next_move), 32'd0);
    check("rst_move_start", 32'(move_start), 32'd0);
    check("rst_completed", 32'(moves_completed), 32'd0);
    check("rst_error", 32'(error), 32'd0);

    // Three moves in order
    enq(4'd2); enq(4'd5); enq(4'd13);
    wait_idle("t1_idle", 500);
    check("t1_count", starts.size(), 32'd3);
    check("t1_m0", 32'(start_at(0)), 32'd2);
    check("t1_m1", 32'(start_at(1)), 32'd5);
    check("t1_m2", 32'(start_at(2)), 32'd13);
    check("t1_completed", 32'(moves_completed), 32'd3);
    check("t1_error", 32'(error), 32'd0);

    // Fill to full while paused; 17th dropped silently
    pause = 1'b1;
    for (int unsigned i = 0; i < 17; i++) begin
      if (i == 15) check("t2_ready15", 32'(move_ready), 32'd1);
      enq(4'(2 + (i % 12)));
      if (i == 15) begin
        check("t2_full_ready", 32'(move_ready), 32'd0);
        check("t2_full_level", 32'(level), 32'd16);
      end
    end
    check("t2_level17", 32'(level), 32'd16);
    check("t2_error", 32'(error), 32'd0);
    check("t2_no_issue", starts.size(), 32'd3);

    // Flush, then flush racing an enqueue
    pulse_flush();
    check("t3_flush_level", 32'(level), 32'd0);
    check("t3_flush_ready", 32'(move_ready), 32'd1);
    @(negedge clock);
    flush = 1'b1; move_in = 4'd4; move_valid = 1'b1;
    @(negedge clock);
    flush = 1'b0; move_valid = 1'b0;
    check("t3_flush_wins", 32'(level), 32'd0);

    // Enqueue and dequeue in the same cycle
    enq(4'd12); enq(4'd13);
    check("t4_level2", 32'(level), 32'd2);
    @(negedge clock);
    pause = 1'b0; move_in = 4'd6; move_valid = 1'b1;
    @(negedge clock);
    move_valid = 1'b0;
    check("t4_same_level", 32'(level), 32'd2);
    check("t4_start", 32'(move_start), 32'd1);
    wait_idle("t4_idle", 500);
    check("t4_m0", 32'(start_at(3)), 32'd12);
    check("t4_m1", 32'(start_at(4)), 32'd13);
    check("t4_m2", 32'(start_at(5)), 32'd6);
    check("t4_completed", 32'(moves_completed), 32'd6);

    // Flush during the first move's busy phase
    pause = 1'b1;
    enq(4'd3); enq(4'd4); enq(4'd5); enq(4'd6);
    n0 = starts.size();
    pause = 1'b0;
    wait_wait_done("t5_wd");
    pulse_flush();
    check("t5_level", 32'(level), 32'd0);
    wait_idle("t5_idle", 500);
    repeat (40) @(negedge clock);
    check("t5_count", starts.size(), n0 + 1);
    check("t5_m0", 32'(start_at(n0)), 32'd3);
    check("t5_completed", 32'(moves_completed), 32'd7);

    // Reset in the middle of a move with three queued behind it
    pause = 1'b1;
    enq(4'd7); enq(4'd8); enq(4'd9); enq(4'd10);
    pause = 1'b0;
    wait_wait_done("t6_wd");
    check("t6_level3", 32'(level), 32'd3);
    check("t6_busy_pre", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_start", 32'(move_start), 32'd0);
    check("t6_next_move", 32'(next_move), 32'd0);
    check("t6_level", 32'(level), 32'd0);
    check("t6_completed", 32'(moves_completed), 32'd0);
    check("t6_ready", 32'(move_ready), 32'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    n0 = starts.size();
    repeat (60) @(negedge clock);
    check("t6_no_start", starts.size(), n0);
    check("t6_level_after", 32'(level), 32'd0);
    enq(4'd11);
    wait_idle("t6_idle", 500);
    check("t6_new_count", starts.size(), n0 + 1);
    check("t6_new_move", 32'(start_at(n0)), 32'd11);
    check("t6_new_completed", 32'(moves_completed), 32'd1);

    // Rejected codes
    pause = 1'b1;
    enq(4'd0);
    check("t7_err0", 32'(error), 32'd1);
    enq(4'd14);
    check("t7_level", 32'(level), 32'd0);
    check("t7_error", 32'(error), 32'd1);
    pause = 1'b0;
    do_reset();
    check("t7_err_cleared", 32'(error), 32'd0);

    // Start timeout: move_done never falls
    dp_auto = 1'b0;
    enq(4'd9);
    n0 = 0;
    while (!move_start && n0 < 10) begin
      @(negedge clock);
      n0++;
    end
    check("t8_start", 32'(move_start), 32'd1);
    check("t8_nm", 32'(next_move), 32'd9);
    repeat (1024) @(negedge clock);
    check("t8_err_early", 32'(error), 32'd0);
    check("t8_busy_early", 32'(busy), 32'd1);
    @(negedge clock);
    check("t8_err", 32'(error), 32'd1);
    check("t8_idle", 32'(busy), 32'd0);
    check("t8_completed", 32'(moves_completed), 32'd0);
    check("t8_level", 32'(level), 32'd0);

    check("nm_stable", unstable, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
